// File: rtl/cv_tdpram_arb_pkg.sv
// rtl/cv_tdpram_arb_pkg.sv - shared widths and FSM encoding for the RAM port arbiter
package cv_tdpram_arb_pkg;

    localparam int BE_W = 4;
    localparam int D_W  = 32;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/cv_rr_pick.sv
// rtl/cv_rr_pick.sv - combinational round-robin pick: first requester at or above ptr, wrapping
module cv_rr_pick #(
    parameter int NREQ = 4,
    localparam int IW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    always_comb begin
        int i;
        i     = 0;
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            i = (int'(ptr) + k) % NREQ;
            if (!valid && req[i]) begin
                valid    = 1'b1;
                grant[i] = 1'b1;
                idx      = IW'(i);
            end
        end
    end

endmodule

// File: rtl/cv_tdpram_arb.sv
// rtl/cv_tdpram_arb.sv - round-robin arbiter with timed lock sharing one RAM port among NREQ masters
module cv_tdpram_arb
    import cv_tdpram_arb_pkg::*;
#(
    parameter int A_WIDTH  = 10,
    parameter int NREQ     = 4,
    parameter int LOCK_MAX = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ-1:0]         lock,
    input  logic [NREQ*A_WIDTH-1:0] addr,
    input  logic [NREQ*BE_W-1:0]    we,
    input  logic [NREQ*D_W-1:0]     wrdata,
    output logic [NREQ-1:0]         ack,
    output logic [NREQ-1:0]         rdvalid,
    output logic [D_W-1:0]          rddata,
    output logic                    lock_err,
    output logic [A_WIDTH-1:0]      ram_addr,
    output logic                    ram_en,
    output logic [BE_W-1:0]         ram_we,
    output logic [D_W-1:0]          ram_wrdata,
    input  logic [D_W-1:0]          ram_rddata
);

    localparam int IW = $clog2(NREQ);
    localparam int CW = $clog2(LOCK_MAX + 1);

    arb_state_t      state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d, owner_q, owner_d;
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
    logic [NREQ-1:0] rdvalid_q;
    logic [NREQ-1:0] pick_grant, gnt_oh;
    logic [IW-1:0]   pick_idx, gnt_idx;
    logic            pick_valid, gnt, force_rel;

    cv_rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        lock_cnt_d = lock_cnt_q;
        gnt        = 1'b0;
        gnt_idx    = pick_idx;
        gnt_oh     = pick_grant;
        force_rel  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    gnt   = 1'b1;
                    ptr_d = (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
                    if (lock[pick_idx]) begin
                        state_d    = ST_LOCKED;
                        owner_d    = pick_idx;
                        lock_cnt_d = CW'(1);
                    end
                end
            end
            ST_LOCKED: begin
                gnt_idx          = owner_q;
                gnt_oh           = '0;
                gnt_oh[owner_q]  = 1'b1;
                lock_cnt_d       = lock_cnt_q + 1'b1;
                // Timeout only bites if the owner still wants the lock this cycle.
                if (lock_cnt_q == CW'(LOCK_MAX) && lock[owner_q]) begin
                    force_rel = 1'b1;
                    state_d   = ST_IDLE;
                    ptr_d     = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
                end else begin
                    gnt = req[owner_q];
                    if (!lock[owner_q]) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (rst) begin
            gnt = 1'b0;
        end
    end

    always_comb begin
        ack        = '0;
        ram_en     = gnt;
        ram_addr   = '0;
        ram_we     = '0;
        ram_wrdata = '0;
        if (gnt) begin
            ack        = gnt_oh;
            ram_addr   = addr[int'(gnt_idx) * A_WIDTH +: A_WIDTH];
            ram_we     = we[int'(gnt_idx) * BE_W +: BE_W];
            ram_wrdata = wrdata[int'(gnt_idx) * D_W +: D_W];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            owner_q    <= '0;
            lock_cnt_q <= '0;
            rdvalid_q  <= '0;
            lock_err   <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            owner_q    <= owner_d;
            lock_cnt_q <= lock_cnt_d;
            // Writes still read old data in the RAM; that data is never flagged.
            rdvalid_q  <= (gnt && ram_we == '0) ? gnt_oh : '0;
            if (force_rel) begin
                lock_err <= 1'b1;
            end
        end
    end

    assign rdvalid = rst ? '0 : rdvalid_q;
    assign rddata  = ram_rddata;

endmodule

// File: tb/tb_cv_tdpram_arb.sv
// tb/tb_cv_tdpram_arb.sv - directed and randomized checks of cv_tdpram_arb against a bench-side model
module tb_cv_tdpram_arb;

    localparam int AW = 10;
    localparam int NR = 4;
    localparam int LM = 16;

    logic            clk = 1'b0;
    logic            rst, mem_clr;
    logic [NR-1:0]   req, lock, ack, rdvalid;
    logic [NR*AW-1:0] addr;
    logic [NR*4-1:0] we;
    logic [NR*32-1:0] wrdata;
    logic [31:0]     rddata, ram_wrdata, ram_rddata;
    logic            lock_err, ram_en;
    logic [AW-1:0]   ram_addr;
    logic [3:0]      ram_we;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    cv_tdpram_arb #(.A_WIDTH(AW), .NREQ(NR), .LOCK_MAX(LM)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .lock       (lock),
        .addr       (addr),
        .we         (we),
        .wrdata     (wrdata),
        .ack        (ack),
        .rdvalid    (rdvalid),
        .rddata     (rddata),
        .lock_err   (lock_err),
        .ram_addr   (ram_addr),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_wrdata (ram_wrdata),
        .ram_rddata (ram_rddata)
    );

    // Byte-enable RAM port: 1-cycle read latency, old data on write, output held between accesses.
    logic [31:0] ram [0:1023];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int a = 0; a < 1024; a++) ram[a] <= '0;
        end else if (ram_en) begin
            ram_rddata <= ram[ram_addr];
            for (int b = 0; b < 4; b++)
                if (ram_we[b]) ram[ram_addr][8*b +: 8] <= ram_wrdata[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: arbitration decided from the request vector and round-robin rules.
    logic [31:0]   m_mem [0:1023];
    bit            m_locked = 1'b0;
    int            m_ptr = 0, m_owner = 0, m_cnt = 0;
    bit            m_err = 1'b0;
    logic [NR-1:0] m_rdv = '0, m_ack_last = '0;
    logic [31:0]   m_rdata = '0;

    always @(negedge clk) begin
        int            g;
        bit            forced;
        logic [NR-1:0] e_ack;
        logic [AW-1:0] ga;
        logic [3:0]    gw;
        logic [31:0]   gd;
        g = -1; forced = 1'b0; e_ack = '0; ga = '0; gw = '0; gd = '0;
        if (!rst) begin
            if (!m_locked) begin
                for (int k = 0; k < NR; k++)
                    if (g < 0 && req[(m_ptr + k) % NR]) g = (m_ptr + k) % NR;
            end else if (m_cnt >= LM && lock[m_owner]) begin
                forced = 1'b1;
            end else if (req[m_owner]) begin
                g = m_owner;
            end
        end
        if (g >= 0) begin
            e_ack[g] = 1'b1;
            ga = addr[g*AW +: AW];
            gw = we[g*4 +: 4];
            gd = wrdata[g*32 +: 32];
        end
        chk("ack", ack, e_ack);
        chk("ram_en", ram_en, g >= 0);
        chk("ram_addr", ram_addr, ga);
        chk("ram_we", ram_we, gw);
        chk("ram_wrdata", ram_wrdata, gd);
        chk("rdvalid", rdvalid, rst ? '0 : m_rdv);
        if (!rst && m_rdv != '0) chk("rddata", rddata, m_rdata);
        chk("lock_err", lock_err, m_err);

        if (mem_clr) for (int a = 0; a < 1024; a++) m_mem[a] = '0;
        if (rst) begin
            m_locked = 1'b0; m_ptr = 0; m_owner = 0; m_cnt = 0; m_rdv = '0; m_err = 1'b0;
        end else begin
            m_rdv = (g >= 0 && gw == 4'b0000) ? e_ack : '0;
            if (g >= 0) begin
                m_rdata = m_mem[ga];
                for (int b = 0; b < 4; b++)
                    if (gw[b]) m_mem[ga][8*b +: 8] = gd[8*b +: 8];
            end
            if (!m_locked) begin
                if (g >= 0) begin
                    m_ptr = (g + 1) % NR;
                    if (lock[g]) begin
                        m_locked = 1'b1; m_owner = g; m_cnt = 1;
                    end
                end
            end else if (forced) begin
                m_locked = 1'b0; m_err = 1'b1; m_ptr = (m_owner + 1) % NR;
            end else if (!lock[m_owner]) begin
                m_locked = 1'b0;
            end else begin
                m_cnt++;
            end
        end
        m_ack_last = e_ack;
    end

    task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [3:0] w, input logic [31:0] d);
        addr[i*AW +: AW]   = a;
        we[i*4 +: 4]       = w;
        wrdata[i*32 +: 32] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [AW-1:0] t6a [4];
    logic [31:0]   t6d [4];

    initial begin
        rst = 1'b1; mem_clr = 1'b1; req = '0; lock = '0; addr = '0; we = '0; wrdata = '0;
        t6a[0] = 10'h010; t6a[1] = 10'h100; t6a[2] = 10'h101; t6a[3] = 10'h103;
        t6d[0] = 32'hDEADBE55; t6d[1] = 32'hA0000000; t6d[2] = 32'hA0000001; t6d[3] = 32'hA0000003;
        step(); step();
        for (int i = 0; i < NR; i++) set_slot(i, AW'(10'h100 + i), 4'hF, 32'hA0000000 | i);
        req = 4'hF;
        #2;
        chk("rst_ack", ack, 4'h0);
        chk("rst_ram_en", ram_en, 1'b0);
        chk("rst_rdvalid", rdvalid, 4'h0);
        chk("rst_lock_err", lock_err, 1'b0);
        step();
        rst = 1'b0; mem_clr = 1'b0;

        // 1: all four writing -> strict rotation
        for (int c = 0; c < 8; c++) begin
            #2;
            chk("t1_ack", ack, 4'b0001 << (c % 4));
            chk("t1_en", ram_en, 1'b1);
            step();
        end
        req = '0; step();

        // 2: full write, byte-lane write, read back merged word
        set_slot(0, 10'h010, 4'hF, 32'hDEADBEEF); req = 4'b0001;
        #2; chk("t2_ack_w0", ack, 4'b0001); step();
        set_slot(0, 10'h010, 4'h1, 32'h00000055);
        #2; chk("t2_ack_w1", ack, 4'b0001); step();
        set_slot(2, 10'h010, 4'h0, 32'h0); req = 4'b0100;
        #2; chk("t2_ack_rd", ack, 4'b0100); step();
        req = '0;
        #2; chk("t2_rdvalid", rdvalid, 4'b0100); chk("t2_rddata", rddata, 32'hDEADBE55); step();

        // 3: locked read-modify-write is not interleaved
        set_slot(0, 10'h020, 4'hF, 32'h0F0F0F0F); req = 4'b0001;
        #2; chk("t3_pre", ack, 4'b0001); step();
        set_slot(0, 10'h021, 4'hF, 32'h11111111);
        set_slot(1, 10'h010, 4'h0, 32'h0);
        set_slot(3, 10'h023, 4'hF, 32'h33333333);
        lock = 4'b0010; req = 4'b1011;
        #2; chk("t3_ack_a", ack, 4'b0010); step();
        set_slot(1, 10'h030, 4'hF, 32'h22222222); lock = '0;
        #2; chk("t3_ack_b", ack, 4'b0010); step();
        req = 4'b1001;
        #2; chk("t3_ack_c", ack, 4'b1000); step();
        req = 4'b0001;
        #2; chk("t3_ack_d", ack, 4'b0001); step();
        req = '0; step();

        // 4: lock held past LOCK_MAX -> forced release, error, next in line served
        set_slot(1, 10'h010, 4'h0, 32'h0);
        set_slot(2, 10'h040, 4'hF, 32'h44444444);
        lock = 4'b0010; req = 4'b0110;
        for (int c = 0; c < LM; c++) begin
            #2; chk("t4_locked_ack", ack, 4'b0010); step();
        end
        #2; chk("t4_forced_ack", ack, 4'b0000); step();
        #2; chk("t4_next_ack", ack, 4'b0100); chk("t4_lock_err", lock_err, 1'b1);
        req = '0; lock = '0; step();

        // 5: reset right after a read grant
        set_slot(0, 10'h010, 4'h0, 32'h0); req = 4'b0001;
        #2; chk("t5_rd_ack", ack, 4'b0001); step();
        rst = 1'b1; req = '0;
        #2; chk("t5_rst_ack", ack, 4'b0000); chk("t5_rst_en", ram_en, 1'b0);
        chk("t5_rst_rdvalid", rdvalid, 4'b0000); step();
        rst = 1'b0; set_slot(3, 10'h010, 4'h0, 32'h0); req = 4'b1000;
        #2; chk("t5_rdvalid", rdvalid, 4'b0000); chk("t5_lock_err", lock_err, 1'b0);
        chk("t5_ack", ack, 4'b1000); step();
        req = '0; step();

        // 6: single requester, back-to-back reads
        for (int c = 0; c < 4; c++) begin
            set_slot(3, t6a[c], 4'h0, 32'h0); req = 4'b1000;
            #2; chk("t6_ack", ack, 4'b1000);
            if (c > 0) begin
                chk("t6_rdvalid", rdvalid, 4'b1000); chk("t6_rddata", rddata, t6d[c-1]);
            end
            step();
        end
        req = '0;
        #2; chk("t6_rdvalid_last", rdvalid, 4'b1000); chk("t6_rddata_last", rddata, t6d[3]); step();

        // Random traffic with sticky-ish locks and occasional resets
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom % 400 == 0);
            for (int i = 0; i < NR; i++) begin
                if (req[i] && m_ack_last[i]) req[i] = 1'b0;
                else if (req[i] && $urandom % 20 == 0) req[i] = 1'b0;
                if (!req[i] && $urandom % 3 == 0) begin
                    req[i] = 1'b1;
                    set_slot(i, AW'($urandom % 32), ($urandom % 2 == 0) ? 4'h0 : 4'($urandom % 16), $urandom);
                end
                if ($urandom % 6 == 0) lock[i] = ~lock[i];
            end
            step();
        end
        rst = 1'b0; req = '0; lock = '0;
        step(); step(); step();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
